// File: rtl/bcd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_controller
// Purpose  : Time-multiplexes one 8421 BCD-to-decimal decoder across NDIGITS
//            display digits. A double-buffered frame is scanned one digit at
//            a time, with a blanking guard slot before each digit, optional
//            leading-zero suppression and invalid-code flagging.
// Ports    : CLK        rising-edge clock
//            RST        synchronous active-high reset
//            EN         scan enable
//            LOAD/READY frame load handshake (accepted on LOAD & READY)
//            DIN        frame data, digit k = DIN[4k+3:4k]
//            LZB        leading-zero blanking enable, captured with the frame
//            A,B,C,D    BCD code to the decoder (A = LSB), 1111 when blanked
//            DIG        one-hot digit strobe
//            FRAME      one-cycle pulse on the first blank slot after a wrap
//            BAD        one-cycle pulse on SHOW entry of an unmasked code > 9
//            ERR        sticky invalid-code flag
// Revision : 1.0  initial release
// ============================================================================
module bcd_scan_controller #(
  parameter int NDIGITS   = 4,
  parameter int DWELL     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   LOAD,
  input  logic [4*NDIGITS-1:0]   DIN,
  input  logic                   LZB,
  output logic                   READY,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic                   D,
  output logic [NDIGITS-1:0]     DIG,
  output logic                   FRAME,
  output logic                   BAD,
  output logic                   ERR
);

  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NDIGITS - 1);

  logic [1:0]             state;
  logic [SW-1:0]          sel;
  logic [CW-1:0]          cnt;
  logic [4*NDIGITS-1:0]   active;
  logic [4*NDIGITS-1:0]   shadow;
  logic                   active_lzb;
  logic                   shadow_lzb;
  logic                   valid;
  logic                   pending;
  logic                   frame_q;
  logic                   bad_q;
  logic                   err_q;

  logic                   load_acc;
  logic [NDIGITS-1:0]     mask;
  logic [3:0]             cur;
  logic                   show_on;
  logic                   zero_run;
  logic [3:0]             code;

  assign load_acc = LOAD && !pending;
  assign cur      = active[{sel, 2'b00} +: 4];

  // A digit is masked when LZB is set for this frame and it and every digit
  // above it are zero. Digit 0 is never masked so a zero frame still shows 0.
  always_comb begin
    zero_run = 1'b1;
    mask     = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (active[4*i +: 4] == 4'd0);
      mask[i]  = active_lzb && zero_run;
    end
  end

  assign show_on = (state == ST_SHOW) && !mask[sel];

  // Blanking rule: whenever no strobe is active the decoder sees 1111.
  always_comb begin
    DIG  = '0;
    code = 4'hF;
    if (show_on) begin
      DIG  = NDIGITS'(1) << sel;
      code = cur;
    end
  end

  assign A     = code[0];
  assign B     = code[1];
  assign C     = code[2];
  assign D     = code[3];
  assign READY = !pending;
  assign FRAME = frame_q;
  assign BAD   = bad_q;
  assign ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      sel        <= '0;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      active_lzb <= 1'b0;
      shadow_lzb <= 1'b0;
      valid      <= 1'b0;
      pending    <= 1'b0;
      frame_q    <= 1'b0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      bad_q   <= 1'b0;
      // Load clears ERR; a set later in this block overrides it.
      if (load_acc) err_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (load_acc && EN) begin
            active     <= DIN;
            active_lzb <= LZB;
            valid      <= 1'b1;
            state      <= ST_BLANK;
            sel        <= '0;
            cnt        <= '0;
          end else if (load_acc) begin
            shadow     <= DIN;
            shadow_lzb <= LZB;
            pending    <= 1'b1;
          end else if (EN && (valid || pending)) begin
            if (pending) begin
              active     <= shadow;
              active_lzb <= shadow_lzb;
              pending    <= 1'b0;
            end
            valid <= 1'b1;
            state <= ST_BLANK;
            sel   <= '0;
            cnt   <= '0;
          end
        end

        ST_BLANK, ST_SHOW: begin
          // A load while scanning always parks in the shadow buffer. It can
          // never collide with the boundary swap: a swap needs pending=1,
          // which holds READY low and blocks the load.
          if (load_acc) begin
            shadow     <= DIN;
            shadow_lzb <= LZB;
            pending    <= 1'b1;
          end
          if (!EN) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
          end else if (state == ST_BLANK) begin
            if (cnt == BLANK_LAST) begin
              state <= ST_SHOW;
              cnt   <= '0;
              if (!mask[sel] && (cur > 4'd9)) begin
                bad_q <= 1'b1;
                err_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            if (cnt == DWELL_LAST) begin
              state <= ST_BLANK;
              cnt   <= '0;
              if (sel == SEL_LAST) begin
                sel     <= '0;
                frame_q <= 1'b1;
                if (pending) begin
                  active     <= shadow;
                  active_lzb <= shadow_lzb;
                  pending    <= 1'b0;
                end
              end else begin
                sel <= sel + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          sel   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_controller
// Purpose  : Self-checking bench for bcd_scan_controller. A frame-position
//            reference model predicts every output each cycle; directed
//            scenarios are followed by randomized traffic.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_scan_controller;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 1;
  localparam int SL = BL + DW;
  localparam int P  = N * SL;

  logic          clk = 1'b0;
  logic          rst, en, load, lzb;
  logic [15:0]   din;
  logic          ready, a, b, c, d, frame, bad, err;
  logic [N-1:0]  dig;

  int checks = 0;
  int errors = 0;

  // Reference model state: scan position within the frame, frame buffers.
  bit          m_run, m_first, m_valid, m_pend, m_err, m_lzb, m_shlzb;
  int          m_pos;
  logic [15:0] m_act, m_sh;

  bcd_scan_controller #(.NDIGITS(N), .DWELL(DW), .BLANK_CYC(BL)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .DIN(din), .LZB(lzb),
    .READY(ready), .A(a), .B(b), .C(c), .D(d), .DIG(dig),
    .FRAME(frame), .BAD(bad), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_of(input int k);
    logic [15:0] t;
    t = m_act >> (4 * k);
    return t[3:0];
  endfunction

  function automatic bit masked(input int k);
    return m_lzb && (k > 0) && ((m_act >> (4 * k)) == 16'd0);
  endfunction

  function automatic bit visible();
    int slot;
    slot = m_pos / SL;
    return m_run && ((m_pos % SL) >= BL) && !masked(slot);
  endfunction

  function automatic logic [3:0] exp_dig();
    return visible() ? 4'(1 << (m_pos / SL)) : 4'd0;
  endfunction

  function automatic logic [3:0] exp_code();
    return visible() ? digit_of(m_pos / SL) : 4'hF;
  endfunction

  function automatic bit exp_bad();
    return visible() && ((m_pos % SL) == BL) && (digit_of(m_pos / SL) > 4'd9);
  endfunction

  task automatic start_scan();
    m_run   = 1;
    m_pos   = 0;
    m_first = 1;
  endtask

  task automatic swap_in();
    m_act  = m_sh;
    m_lzb  = m_shlzb;
    m_pend = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = load && !m_pend;
    if (rst) begin
      m_run = 0; m_pos = 0; m_first = 1; m_act = '0; m_sh = '0;
      m_lzb = 0; m_shlzb = 0; m_valid = 0; m_pend = 0; m_err = 0;
      return;
    end
    if (!m_run) begin
      if (acc && en) begin
        m_act = din; m_lzb = lzb; m_valid = 1;
        start_scan();
      end else if (acc) begin
        m_sh = din; m_shlzb = lzb; m_pend = 1;
      end else if (en && (m_valid || m_pend)) begin
        if (m_pend) swap_in();
        m_valid = 1;
        start_scan();
      end
    end else begin
      if (!en) begin
        m_run = 0;
      end else begin
        m_pos++;
        if (m_pos == P) begin
          m_pos   = 0;
          m_first = 0;
          if (m_pend) swap_in();
        end
      end
      if (acc) begin
        m_sh = din; m_shlzb = lzb; m_pend = 1;
      end
    end
    if (acc) m_err = 0;
    if (exp_bad()) m_err = 1;
  endtask

  task automatic compare_outputs();
    check("dig",   32'(dig),            32'(exp_dig()));
    check("code",  32'({d, c, b, a}),   32'(exp_code()));
    check("frame", 32'(frame),          32'(m_run && (m_pos == 0) && !m_first));
    check("bad",   32'(bad),            32'(exp_bad()));
    check("err",   32'(err),            32'(m_err));
    check("ready", 32'(ready),          32'(!m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic z);
    din = v; lzb = z; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 3 * P; i++) begin
      if (m_run && (m_pos == p)) break;
      step();
    end
    check("wait_pos", 32'(m_pos), 32'(p));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3 * P; i++) begin
      if (!m_pend) break;
      step();
    end
    check("wait_ready", 32'(ready), 32'd1);
  endtask

  function automatic logic [15:0] rand_frame();
    logic [15:0] f;
    int top;
    f   = '0;
    top = $urandom_range(0, N - 1);
    for (int k = 0; k <= top; k++)
      f[4*k +: 4] = (($urandom % 8) == 0) ? 4'($urandom_range(10, 15))
                                          : 4'($urandom_range(0, 9));
    return f;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; lzb = 1'b0; din = '0;
    step();
    check("rst_dig",   32'(dig),          32'd0);
    check("rst_code",  32'({d, c, b, a}), 32'hF);
    check("rst_ready", 32'(ready),        32'd1);
    rst = 1'b0;

    // Basic scan of 1905.
    en = 1'b1;
    pulse_load(16'h1905, 1'b0);
    run(2 * P + 3);

    // Mid-frame load, then a blocked second load.
    wait_pos(7);
    pulse_load(16'h0042, 1'b0);
    check("ready_drop", 32'(ready), 32'd0);
    pulse_load(16'h9999, 1'b1);
    run(2 * P);

    // Leading-zero suppression.
    wait_ready();
    pulse_load(16'h0007, 1'b1);
    run(2 * P + 2);
    wait_ready();
    pulse_load(16'h0000, 1'b1);
    run(2 * P + 2);

    // Invalid code, then a clearing load.
    wait_ready();
    pulse_load(16'h00B3, 1'b0);
    run(2 * P + 2);
    wait_ready();
    pulse_load(16'h0012, 1'b0);
    run(2 * P + 2);

    // EN dropped during digit 2 SHOW, then restarted.
    wait_pos(2 * SL + BL + 1);
    en = 1'b0;
    step();
    check("en_off_code", 32'({d, c, b, a}), 32'hF);
    run(3);
    en = 1'b1;
    run(P + 2);

    // Reset in the middle of a SHOW slot; no scan until a new load.
    wait_pos(SL + BL + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(10);
    pulse_load(16'h4321, 1'b0);
    run(P);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst  = (($urandom % 400) == 0);
      en   = (($urandom % 20) != 0);
      load = (($urandom % 10) == 0);
      lzb  = 1'($urandom % 2);
      din  = rand_frame();
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
